binary_to_onehot: RTL and testbench

Parameterised binary-to-one-hot decoder. It converts a BIN_W-bit index into a ONE_HOT_W-bit vector with exactly one bit set. A combinational output serves same-cycle consumers. A registered copy with a valid flag serves pipelined consumers in the clk_i domain. Typical uses are arbiters, demux selects and register-file write enables.

---
 rtl/binary_to_onehot.sv | 71 +++++++
 tb/tb_binary_to_onehot.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_onehot.sv
// binary_to_onehot
//   Parameterised binary-to-one-hot decoder with a combinational output for
//   same-cycle consumers and a registered copy (with valid flag) for
//   pipelined consumers.
//
// Parameters
//   BIN_W      width of the binary index (1..8)
//   ONE_HOT_W  width of the one-hot vector (1..2**BIN_W)
//
// Ports
//   clk_i        clock, registered path updates on rising edge
//   rst_i        asynchronous active-high reset of the registered path
//   bin_i        binary index to decode
//   en_i         capture enable for the registered path
//   one_hot_o    combinational decode of bin_i (all zero when out of range)
//   oor_o        combinational, 1 when bin_i >= ONE_HOT_W
//   one_hot_q_o  registered decode
//   valid_q_o    registered, 1 when one_hot_q_o holds a legal one-hot value
//   oor_q_o      registered copy of oor_o
module binary_to_onehot #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 1 << BIN_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BIN_W-1:0]     bin_i,
  input  logic                 en_i,
  output logic [ONE_HOT_W-1:0] one_hot_o,
  output logic                 oor_o,
  output logic [ONE_HOT_W-1:0] one_hot_q_o,
  output logic                 valid_q_o,
  output logic                 oor_q_o
);

  if (BIN_W < 1 || BIN_W > 8) begin : g_bad_bin_w
    $fatal(1, "binary_to_onehot: BIN_W=%0d outside 1..8", BIN_W);
  end

  if (ONE_HOT_W < 1 || ONE_HOT_W > (1 << BIN_W)) begin : g_bad_one_hot_w
    $fatal(1, "binary_to_onehot: ONE_HOT_W=%0d outside 1..2**BIN_W", ONE_HOT_W);
  end

  logic [31:0] bin_ext;

  assign bin_ext = 32'(bin_i);

  // Per-bit compare rather than a shift: produces the full ONE_HOT_W-wide
  // vector without truncation and naturally yields zero for indices that
  // fall beyond the last output bit.
  always_comb begin
    one_hot_o = '0;
    for (int unsigned k = 0; k < ONE_HOT_W; k++) begin
      one_hot_o[k] = (bin_ext == k);
    end
  end

  assign oor_o = (bin_ext >= 32'(ONE_HOT_W));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      one_hot_q_o <= '0;
      valid_q_o   <= 1'b0;
      oor_q_o     <= 1'b0;
    end else if (en_i) begin
      one_hot_q_o <= one_hot_o;
      oor_q_o     <= oor_o;
      valid_q_o   <= ~oor_o;
    end
  end

endmodule

// File: tb/tb_binary_to_onehot.sv
module tb_binary_to_onehot;

  typedef struct {
    logic [3:0]  bin;
    logic [15:0] oh;
    logic        oor;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en;

  logic [3:0]  bin16;
  logic [15:0] oh16, ohq16;
  logic        oor16, oorq16, vq16;

  logic [3:0]  bin10;
  logic [9:0]  oh10, ohq10;
  logic        oor10, oorq10, vq10;

  logic        bin2;
  logic [1:0]  oh2, ohq2;
  logic        oor2, oorq2, vq2;

  int checks = 0;
  int errors = 0;

  binary_to_onehot #(.BIN_W(4), .ONE_HOT_W(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .bin_i(bin16), .en_i(en),
    .one_hot_o(oh16), .oor_o(oor16),
    .one_hot_q_o(ohq16), .valid_q_o(vq16), .oor_q_o(oorq16)
  );

  binary_to_onehot #(.BIN_W(4), .ONE_HOT_W(10)) u_dut10 (
    .clk_i(clk), .rst_i(rst), .bin_i(bin10), .en_i(en),
    .one_hot_o(oh10), .oor_o(oor10),
    .one_hot_q_o(ohq10), .valid_q_o(vq10), .oor_q_o(oorq10)
  );

  binary_to_onehot #(.BIN_W(1), .ONE_HOT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bin_i(bin2), .en_i(en),
    .one_hot_o(oh2), .oor_o(oor2),
    .one_hot_q_o(ohq2), .valid_q_o(vq2), .oor_q_o(oorq2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Registered invariant on the 16-wide instance.
  task automatic check_inv16();
    if (vq16 === 1'b1) check("inv16_countones", 32'($countones(ohq16)), 32'd1);
    else               check("inv16_zero", 32'(ohq16), 32'h0);
  endtask

  // Advance one clock and sample shortly after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    check_inv16();
  endtask

  vec_t v16[16];
  vec_t v10[5];

  initial begin
    v16[0]  = '{4'd0,  16'h0001, 1'b0};
    v16[1]  = '{4'd1,  16'h0002, 1'b0};
    v16[2]  = '{4'd2,  16'h0004, 1'b0};
    v16[3]  = '{4'd3,  16'h0008, 1'b0};
    v16[4]  = '{4'd4,  16'h0010, 1'b0};
    v16[5]  = '{4'd5,  16'h0020, 1'b0};
    v16[6]  = '{4'd6,  16'h0040, 1'b0};
    v16[7]  = '{4'd7,  16'h0080, 1'b0};
    v16[8]  = '{4'd8,  16'h0100, 1'b0};
    v16[9]  = '{4'd9,  16'h0200, 1'b0};
    v16[10] = '{4'd10, 16'h0400, 1'b0};
    v16[11] = '{4'd11, 16'h0800, 1'b0};
    v16[12] = '{4'd12, 16'h1000, 1'b0};
    v16[13] = '{4'd13, 16'h2000, 1'b0};
    v16[14] = '{4'd14, 16'h4000, 1'b0};
    v16[15] = '{4'd15, 16'h8000, 1'b0};

    v10[0]  = '{4'd0,  16'h0001, 1'b0};
    v10[1]  = '{4'd9,  16'h0200, 1'b0};
    v10[2]  = '{4'd10, 16'h0000, 1'b1};
    v10[3]  = '{4'd12, 16'h0000, 1'b1};
    v10[4]  = '{4'd15, 16'h0000, 1'b1};

    rst   = 1'b1;
    en    = 1'b0;
    bin16 = '0;
    bin10 = '0;
    bin2  = 1'b0;
    #2;

    // Reset state of every registered output.
    check("rst_ohq16", 32'(ohq16), 32'h0);
    check("rst_vq16",  32'(vq16),  32'h0);
    check("rst_oorq16", 32'(oorq16), 32'h0);
    check("rst_ohq10", 32'(ohq10), 32'h0);
    check("rst_ohq2",  32'(ohq2),  32'h0);

    // Combinational sweep; runs while reset is held to show independence.
    for (int i = 0; i < 16; i++) begin
      bin16 = v16[i].bin;
      #10;
      check($sformatf("comb16_oh[%0d]", i), 32'(oh16), 32'(v16[i].oh));
      check($sformatf("comb16_oor[%0d]", i), 32'(oor16), 32'(v16[i].oor));
      check($sformatf("comb16_cnt[%0d]", i), 32'($countones(oh16)), 32'd1);
    end

    for (int i = 0; i < 5; i++) begin
      bin10 = v10[i].bin;
      #10;
      check($sformatf("comb10_oh[%0d]", i), 32'(oh10), 32'(v10[i].oh));
      check($sformatf("comb10_oor[%0d]", i), 32'(oor10), 32'(v10[i].oor));
    end

    bin2 = 1'b0;
    #10;
    check("comb2_oh0", 32'(oh2), 32'h1);
    check("comb2_oor0", 32'(oor2), 32'h0);
    bin2 = 1'b1;
    #10;
    check("comb2_oh1", 32'(oh2), 32'h2);

    // Enable held during reset must not capture.
    en = 1'b1;
    step();
    check("rst_hold_ohq16", 32'(ohq16), 32'h0);
    check("rst_hold_vq16",  32'(vq16),  32'h0);

    // Release reset, then back-to-back captures 0, 7, 15.
    @(negedge clk);
    rst = 1'b0;
    bin16 = 4'd0;
    step();
    check("b2b_ohq_0", 32'(ohq16), 32'h0001);
    check("b2b_vq_0",  32'(vq16),  32'h1);
    @(negedge clk);
    bin16 = 4'd7;
    step();
    check("b2b_ohq_7", 32'(ohq16), 32'h0080);
    check("b2b_vq_7",  32'(vq16),  32'h1);
    @(negedge clk);
    bin16 = 4'd15;
    step();
    check("b2b_ohq_15", 32'(ohq16), 32'h8000);
    check("b2b_vq_15",  32'(vq16),  32'h1);
    check("b2b_oorq_15", 32'(oorq16), 32'h0);

    // Capture then hold with enable low.
    @(negedge clk);
    bin16 = 4'd3;
    step();
    check("hold_cap", 32'(ohq16), 32'h0008);
    @(negedge clk);
    en = 1'b0;
    bin16 = 4'd9;
    step();
    step();
    check("hold_ohq", 32'(ohq16), 32'h0008);
    check("hold_vq",  32'(vq16),  32'h1);
    check("hold_oh_comb", 32'(oh16), 32'h0200);

    // Mid-cycle asynchronous reset with a capture pending.
    @(negedge clk);
    en = 1'b1;
    bin16 = 4'd5;
    #2;
    rst = 1'b1;
    #1;
    check("async_ohq", 32'(ohq16), 32'h0);
    check("async_vq",  32'(vq16),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("release_ohq", 32'(ohq16), 32'h0020);
    check("release_vq",  32'(vq16),  32'h1);

    // Out-of-range capture on the 10-wide instance.
    @(negedge clk);
    bin10 = 4'd9;
    step();
    check("w10_ohq_9",  32'(ohq10),  32'h200);
    check("w10_vq_9",   32'(vq10),   32'h1);
    check("w10_oorq_9", 32'(oorq10), 32'h0);
    @(negedge clk);
    bin10 = 4'd12;
    step();
    check("w10_ohq_12",  32'(ohq10),  32'h000);
    check("w10_vq_12",   32'(vq10),   32'h0);
    check("w10_oorq_12", 32'(oorq10), 32'h1);

    // Narrow instance registered path.
    @(negedge clk);
    bin2 = 1'b0;
    step();
    check("w2_ohq_0", 32'(ohq2), 32'h1);
    @(negedge clk);
    bin2 = 1'b1;
    step();
    check("w2_ohq_1", 32'(ohq2), 32'h2);
    check("w2_vq_1",  32'(vq2),  32'h1);
    check("w2_oorq_1", 32'(oorq2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
